// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and writeback port type for the scoreboarded register file.
// The writeback struct is sized for the largest supported configuration (XLEN <= 64, NREGS <= 256).
package regfile_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_DEF   = 32;
    localparam int WB_AW_MAX   = 8;
    localparam int WB_XLEN_MAX = 64;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    typedef struct packed {
        logic                   en;
        logic [WB_AW_MAX-1:0]   addr;
        logic [WB_XLEN_MAX-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, plus a same-cycle writeback bypass mux
// when SCOREBOARD_REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic [AW-1:0]               i_addr,
    input  logic [NREGS-1:0][XLEN-1:0]  i_regs,
    input  logic [NREGS-1:0]            i_busy,
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    input  wb_port_t                    i_wb0,
    input  wb_port_t                    i_wb1,
    input  logic                        i_iss_valid,
    input  logic [AW-1:0]               i_iss_rd,
`endif
    output logic [XLEN-1:0]             o_data,
    output logic                        o_busy
);

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    logic w_hit0;
    logic w_hit1;
    logic w_iss_hit;
    logic w_unused_data;

    assign w_hit0        = i_wb0.en && (i_addr != '0) && (i_wb0.addr == WB_AW_MAX'(i_addr));
    assign w_hit1        = i_wb1.en && (i_addr != '0) && (i_wb1.addr == WB_AW_MAX'(i_addr));
    assign w_iss_hit     = i_iss_valid && (i_addr != '0) && (i_iss_rd == i_addr);
    assign w_unused_data = ^{i_wb0.data, i_wb1.data};

    // A forwarded value is no longer pending unless a new producer issues in the same cycle.
    always_comb begin
        o_data = i_regs[i_addr];
        o_busy = i_busy[i_addr];
        if (w_hit1) begin
            o_data = i_wb1.data[XLEN-1:0];
            o_busy = w_iss_hit;
        end else if (w_hit0) begin
            o_data = i_wb0.data[XLEN-1:0];
            o_busy = w_iss_hit;
        end
    end
`else
    assign o_data = i_regs[i_addr];
    assign o_busy = i_busy[i_addr];
`endif

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard, two writeback ports and NRD read ports.
// Optional same-cycle read bypass is enabled by defining SCOREBOARD_REGFILE_BYPASS_EN.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = addr_width(NREGS),
    localparam int CW   = AW + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wb0_en,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_en,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    output logic [CW-1:0]       pending_cnt
);

    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0]           r_busy;
    logic [CW-1:0]              r_cnt;

    wb_port_t         w_wb0;
    wb_port_t         w_wb1;
    logic [NREGS-1:0] w_wr0;
    logic [NREGS-1:0] w_wr1;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_unused_wb;

    assign w_wb0 = '{en: wb0_en, addr: WB_AW_MAX'(wb0_addr), data: WB_XLEN_MAX'(wb0_data)};
    assign w_wb1 = '{en: wb1_en, addr: WB_AW_MAX'(wb1_addr), data: WB_XLEN_MAX'(wb1_data)};
    assign w_unused_wb = ^{w_wb0.data, w_wb1.data};

    // Decode starts at 1: register 0 is never written, issued or marked busy.
    always_comb begin
        // NOTE: every variable gets a default before any conditional logic, so no latch is inferred.
        w_wr0     = '0;
        w_wr1     = '0;
        w_set     = '0;
        w_cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_wr0[i] = w_wb0.en && (w_wb0.addr == WB_AW_MAX'(i));
            w_wr1[i] = w_wb1.en && (w_wb1.addr == WB_AW_MAX'(i));
            w_set[i] = iss_valid && (iss_rd == AW'(i));
        end
        // Set after clear: a same-cycle issue is the newer producer and must win.
        w_busy_nxt = (r_busy & ~(w_wr0 | w_wr1)) | w_set;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the data array is reset as well, so every register reads a defined zero after reset.
            r_regs <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state samples pre-edge values regardless of order.
            for (int i = 1; i < NREGS; i++) begin
                if (w_wr1[i]) begin
                    r_regs[i] <= w_wb1.data[XLEN-1:0];
                end else if (w_wr0[i]) begin
                    r_regs[i] <= w_wb0.data[XLEN-1:0];
                end
            end
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign pending_cnt = r_cnt;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .i_addr      (rd_addr[k*AW +: AW]),
            .i_regs      (r_regs),
            .i_busy      (r_busy),
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
            .i_wb0       (w_wb0),
            .i_wb1       (w_wb1),
            .i_iss_valid (iss_valid),
            .i_iss_rd    (iss_rd),
`endif
            .o_data      (w_data),
            .o_busy      (w_busy)
        );

        // Gate with reset so a bypassed writeback cannot leak out while reset is held.
        assign rd_data[k*XLEN +: XLEN] = reset ? '0 : w_data;
        assign rd_busy[k]              = ~reset & w_busy;
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: expectations are queued as stimulus is driven
// and popped against the DUT outputs once they are due.
module tb_scoreboard_regfile;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        wb0_en;
    logic [4:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb1_en;
    logic [4:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic [5:0]  pending_cnt;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    scoreboard_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .wb0_en      (wb0_en),
        .wb0_addr    (wb0_addr),
        .wb0_data    (wb0_data),
        .wb1_en      (wb1_en),
        .wb1_addr    (wb1_addr),
        .wb1_data    (wb1_data),
        .pending_cnt (pending_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(input int kind, input int port);
        case (kind)
            K_DATA:  return rd_data[port*32 +: 32];
            K_BUSY:  return {31'b0, rd_busy[port]};
            default: return {26'b0, pending_cnt};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int kind, input int port, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic exp_reg(input string tag, input int port, input logic [31:0] data, input logic busy);
        push_exp({tag, "_data"}, K_DATA, port, data);
        push_exp({tag, "_busy"}, K_BUSY, port, {31'b0, busy});
    endtask

    task automatic exp_cnt(input string tag, input logic [31:0] cnt);
        push_exp({tag, "_cnt"}, K_CNT, 0, cnt);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.kind, e.port);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ir,
                         input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        iss_valid = iv;
        iss_rd    = ir;
        wb0_en    = e0;
        wb0_addr  = a0;
        wb0_data  = d0;
        wb1_en    = e1;
        wb1_addr  = a1;
        wb1_data  = d1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic read2(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Advance past the next rising edge, drop the inputs, and let reads settle.
    task automatic tick_idle();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        rd_addr = '0;
        idle();
        #1 reset = 1'b1;

        // Traffic during reset must be discarded and outputs held at zero.
        #1;
        read2(5'd4, 5'd5);
        drive(1'b1, 5'd4, 1'b1, 5'd4, 32'hA5A5_A5A5, 1'b1, 5'd5, 32'h5A5A_5A5A);
        #1;
        exp_reg("rst_p0", 0, 32'h0, 1'b0);
        exp_reg("rst_p1", 1, 32'h0, 1'b0);
        exp_cnt("rst", 32'd0);
        check_sb();
        @(posedge clock);
        @(posedge clock);
        #1;
        exp_reg("rst_hold_p0", 0, 32'h0, 1'b0);
        exp_reg("rst_hold_p1", 1, 32'h0, 1'b0);
        exp_cnt("rst_hold", 32'd0);
        check_sb();
        idle();
        reset = 1'b0;
        #1;

        for (int a = 0; a < 32; a += 2) begin
            read2(5'(a), 5'(a + 1));
            #1;
            exp_reg($sformatf("post_rst_x%0d", a), 0, 32'h0, 1'b0);
            exp_reg($sformatf("post_rst_x%0d", a + 1), 1, 32'h0, 1'b0);
            check_sb();
        end
        exp_cnt("post_rst", 32'd0);
        check_sb();

        // Issue x5, then write it back.
        read2(5'd5, 5'd0);
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_reg("x5_issued", 0, 32'h0, 1'b1);
        exp_reg("x0_after_iss", 1, 32'h0, 1'b0);
        exp_cnt("x5_issued", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        exp_reg("x5_written", 0, 32'hDEAD_BEEF, 1'b0);
        exp_cnt("x5_written", 32'd0);
        tick_idle();
        check_sb();

        // Both writeback ports to x7: port 1 data wins.
        read2(5'd7, 5'd7);
        drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        exp_reg("x7_dual_p0", 0, 32'h22, 1'b0);
        exp_reg("x7_dual_p1", 1, 32'h22, 1'b0);
        exp_cnt("x7_dual", 32'd0);
        tick_idle();
        check_sb();

        // Busy x3, then issue and writeback x3 together.
        read2(5'd3, 5'd6);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_reg("x3_issued", 0, 32'h0, 1'b1);
        exp_cnt("x3_issued", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h55);
        exp_reg("x3_iss_wb", 0, 32'h55, 1'b1);
        exp_cnt("x3_iss_wb", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_reg("x3_reissue", 0, 32'h55, 1'b1);
        exp_cnt("x3_reissue", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd6, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        exp_reg("x3_retire", 0, 32'h33, 1'b0);
        exp_reg("x6_issued", 1, 32'h0, 1'b1);
        exp_cnt("x3_x6_swap", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
        exp_reg("x6_written", 1, 32'h66, 1'b0);
        exp_cnt("x6_written", 32'd0);
        tick_idle();
        check_sb();

        // Register 0 ignores writes and issues.
        read2(5'd0, 5'd0);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h1234_5678);
        exp_reg("x0_write", 0, 32'h0, 1'b0);
        exp_cnt("x0_write", 32'd0);
        tick_idle();
        check_sb();

        // Same-cycle read of a register being written back.
        read2(5'd9, 5'd9);
        drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h0BAD, 1'b0, 5'd0, 32'h0);
        exp_reg("x9_old", 0, 32'h0BAD, 1'b0);
        tick_idle();
        check_sb();
        drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'h0);
        #1;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        exp_reg("x9_same_cycle_p0", 0, 32'h1234, 1'b0);
        exp_reg("x9_same_cycle_p1", 1, 32'h1234, 1'b0);
`else
        exp_reg("x9_same_cycle_p0", 0, 32'h0BAD, 1'b0);
        exp_reg("x9_same_cycle_p1", 1, 32'h0BAD, 1'b0);
`endif
        check_sb();
        exp_reg("x9_next_cycle", 0, 32'h1234, 1'b0);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5678);
        #1;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        exp_reg("x9_byp_iss", 0, 32'h5678, 1'b1);
`else
        exp_reg("x9_byp_iss", 0, 32'h1234, 1'b0);
`endif
        check_sb();
        exp_reg("x9_iss_wb", 0, 32'h5678, 1'b1);
        exp_cnt("x9_iss_wb", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
        exp_reg("x9_retire", 0, 32'h9, 1'b0);
        exp_cnt("x9_retire", 32'd0);
        tick_idle();
        check_sb();

        // Several pending registers, with a dual writeback that must decrement once.
        read2(5'd10, 5'd11);
        drive(1'b1, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_cnt("multi_1", 32'd1);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_cnt("multi_2", 32'd2);
        tick_idle();
        check_sb();
        read2(5'd12, 5'd13);
        drive(1'b1, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_cnt("multi_3", 32'd3);
        tick_idle();
        check_sb();
        drive(1'b1, 5'd13, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_reg("x12_busy", 0, 32'h0, 1'b1);
        exp_reg("x13_busy", 1, 32'h0, 1'b1);
        exp_cnt("multi_4", 32'd4);
        tick_idle();
        check_sb();
        drive(1'b0, 5'd0, 1'b1, 5'd13, 32'hA, 1'b1, 5'd13, 32'hB);
        exp_reg("x13_dual", 1, 32'hB, 1'b0);
        exp_cnt("x13_dual", 32'd3);
        tick_idle();
        check_sb();
        read2(5'd10, 5'd11);
        drive(1'b0, 5'd0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
        exp_reg("x10_wb", 0, 32'h10, 1'b0);
        exp_reg("x11_wb", 1, 32'h11, 1'b0);
        exp_cnt("x10_x11_wb", 32'd1);
        tick_idle();
        check_sb();

        // Reset in the middle of a cycle clears state at once and discards that cycle's traffic.
        read2(5'd12, 5'd14);
        drive(1'b1, 5'd14, 1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        exp_reg("midrst_x12", 0, 32'h0, 1'b0);
        exp_reg("midrst_x14", 1, 32'h0, 1'b0);
        exp_cnt("midrst", 32'd0);
        check_sb();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        read2(5'd10, 5'd11);
        #1;
        exp_reg("midrst_x10", 0, 32'h0, 1'b0);
        exp_reg("midrst_x11", 1, 32'h0, 1'b0);
        check_sb();
        read2(5'd12, 5'd14);
        exp_reg("after_rst_x12", 0, 32'h77, 1'b0);
        exp_reg("after_rst_x14", 1, 32'h0, 1'b1);
        exp_cnt("after_rst", 32'd1);
        tick_idle();
        check_sb();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, at least 4.
REQ-003 Parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 Derived AW = log2(NREGS); CW = AW+1.
REQ-005 Port clock, input, 1, rising-edge clock for all state.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 rd_addr, input, NRD*AW, packed read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd_data, output, NRD*XLEN, packed read data, same packing as rd_addr.
REQ-009 rd_busy, output, NRD, pending-write flag per read port.
REQ-010 iss_valid, input, 1, instruction issue marks iss_rd as pending.
REQ-011 iss_rd, input, AW, destination register being issued.
REQ-012 wb0_en / wb0_addr / wb0_data, input, 1 / AW / XLEN, writeback port 0 (ALU).
REQ-013 wb1_en / wb1_addr / wb1_data, input, 1 / AW / XLEN, writeback port 1 (load unit).
REQ-014 pending_cnt, output, CW, registered count of busy registers.

Function
REQ-015 Register 0 SHALL read as 0, SHALL never be written, and SHALL never be busy; writes and issues to address 0 are ignored.
REQ-016 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]], rd_busy[k] = busy[rd_addr[k]].
REQ-017 On a rising clock edge, each enabled writeback port SHALL write its data to its nonzero address and clear that register's busy bit.
REQ-018 If both write ports target the same nonzero register in one cycle, port 1 data SHALL be stored; busy SHALL clear once.
REQ-019 iss_valid with nonzero iss_rd SHALL set busy[iss_rd] at the next edge.
REQ-020 Issue and writeback to the same register in one cycle: busy SHALL end set (the new producer wins); writeback data is still stored.
REQ-021 Issue to an already-busy register SHALL leave it busy, with no count change.
REQ-022 Writeback to a non-busy register SHALL store data, leave busy clear, and not decrement the count.
REQ-023 pending_cnt SHALL equal the population count of the busy vector after each edge; it never exceeds NREGS-1 and never wraps.

Reset
REQ-024 Reset SHALL asynchronously clear all registers, all busy bits and pending_cnt to 0; rd_data and rd_busy SHALL read 0 while reset is high.
REQ-025 Reset asserted mid-operation SHALL discard same-cycle issue and writebacks; the first edge after deassertion SHALL operate normally.

Configuration
REQ-026 With macro SCOREBOARD_REGFILE_BYPASS_EN defined, a read whose address matches an enabled same-cycle writeback (nonzero address) SHALL return that writeback's data (port 1 priority) and rd_busy 0, unless iss_valid targets the same register, in which case rd_busy is 1.
REQ-027 Without the macro, reads SHALL return only stored state; the write becomes visible the cycle after the edge.

Structure
REQ-028 Package regfile_pkg SHALL hold the XLEN and NREGS defaults, the AW derivation function, and the writeback port struct type (en, addr, data).
REQ-029 A sub-module regfile_read_port SHALL implement one read port (array select plus optional bypass mux) and SHALL be instantiated NRD times via generate.

Verification
REQ-030 Reset, then read all registers -> rd_data 0, rd_busy 0, pending_cnt 0.
REQ-031 Issue x5; next cycle wb0 x5=0xDEADBEEF -> busy[5] 1 then 0, pending_cnt 1 then 0, x5 reads 0xDEADBEEF.
REQ-032 wb0 x7=0x11, wb1 x7=0x22 in the same cycle -> x7 reads 0x22.
REQ-033 Issue x3 and wb1 x3=0x55 in the same cycle, x3 previously busy -> x3=0x55, busy[3] stays 1, pending_cnt unchanged.
REQ-034 wb0 x0=0xFFFFFFFF with iss_rd 0 -> x0 reads 0, busy[0] 0, pending_cnt 0.
REQ-035 With the bypass macro, wb0 x9=0x1234 while rd_addr[0]=9 -> rd_data[0]=0x1234 in the same cycle; without it, the old value that cycle and 0x1234 the next.
